// File: rtl/bancoreg_pkg.sv
// bancoreg_pkg: shared types, default sizes and port-slicing helper for the register bank
package bancoreg_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  function automatic int lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/bancoreg_rdport.sv
// bancoreg_rdport: one combinational read port with zero register, writeback bypass and clear masking
module bancoreg_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              clearing,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              pend,
  output logic [DATA_W-1:0] data,
  output logic              ready
);
  // clear masks everything, r0 is constant zero, a matching writeback forwards its value
  always_comb begin
    data  = (clearing || addr == '0) ? '0 : (wr_en && wr_addr == addr) ? wr_data : reg_data;
    ready = clearing ? 1'b0 : (addr == '0 || (wr_en && wr_addr == addr)) ? 1'b1 : !pend;
  end
endmodule

// File: rtl/bancoreg_mp.sv
// bancoreg_mp: multi-read-port register file with bypass, pending bits and sequenced bulk clear
module bancoreg_mp
  import bancoreg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       clear_req,
  output logic                       clear_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [ADDR_W-1:0] cnt;
  state_t            state;
  assign clear_busy = state == ST_CLEAR;
  // storage, pending bits and clear sequencer; the clear walks r1..r(DEPTH-1) and holds the counter at the end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
      cnt     <= '0;
      state   <= ST_IDLE;
    end else if (state == ST_CLEAR) begin
      regs[cnt] <= '0;
      cnt       <= (cnt == LAST) ? cnt : cnt + 1'b1;
      state     <= (cnt == LAST) ? ST_IDLE : ST_CLEAR;
    end else if (clear_req) begin
      pending <= '0;
      cnt     <= ADDR_W'(1);
      state   <= ST_CLEAR;
    end else begin
      if (wr_en && wr_addr != '0) begin
        regs[wr_addr]    <= wr_data;
        pending[wr_addr] <= 1'b0;
      end
      if (issue_en && issue_addr != '0) pending[issue_addr] <= 1'b1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[lsb(k, ADDR_W) +: ADDR_W];
    bancoreg_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .addr     (a),
      .clearing (clear_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .reg_data (regs[a]),
      .pend     (pending[a]),
      .data     (rd_data[lsb(k, DATA_W) +: DATA_W]),
      .ready    (rd_ready[k])
    );
  end
endmodule

// File: tb/tb_bancoreg_mp.sv
// tb_bancoreg_mp: scoreboard bench with a behavioural register-file model and randomized traffic
module tb_bancoreg_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int DEPTH = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic             wr_en, issue_en, clear_req, clear_busy;
  logic [AW-1:0]    wr_addr, issue_addr;
  logic [DW-1:0]    wr_data;

  bancoreg_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .clear_req  (clear_req),
    .clear_busy (clear_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string            name;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    ready;
    logic             busy;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model: register values, pending flags, and how many busy cycles remain
  logic [DW-1:0] mdl [DEPTH];
  bit            pend [DEPTH];
  int            busy_left;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0;
      pend[i] = 0;
    end
    busy_left = 0;
  endfunction

  // one rising edge of architectural behaviour; the clear is seen only as a busy window
  // after which every register is zero
  function automatic void model_edge();
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    end else if (clear_req) begin
      for (int i = 0; i < DEPTH; i++) pend[i] = 0;
      busy_left = DEPTH - 1;
    end else begin
      if (wr_en && wr_addr != 0) begin
        mdl[wr_addr] = wr_data;
        pend[wr_addr] = 0;
      end
      if (issue_en && issue_addr != 0) pend[issue_addr] = 1;
    end
  endfunction

  task automatic push(input string nm);
    exp_t e;
    int a;
    e.name = nm;
    e.busy = busy_left > 0;
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      if (busy_left > 0) begin
        e.data[k*DW +: DW] = '0;
        e.ready[k] = 1'b0;
      end else if (a == 0) begin
        e.data[k*DW +: DW] = '0;
        e.ready[k] = 1'b1;
      end else if (wr_en && int'(wr_addr) == a) begin
        e.data[k*DW +: DW] = wr_data;
        e.ready[k] = 1'b1;
      end else begin
        e.data[k*DW +: DW] = mdl[a];
        e.ready[k] = !pend[a];
      end
    end
    q.push_back(e);
  endtask

  function automatic logic [NR*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic cyc(input string nm, input int we, input int wa, input logic [DW-1:0] wd,
                     input int ie, input int ia, input int cr, input logic [NR*AW-1:0] ra);
    wr_en      = we != 0;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    issue_en   = ie != 0;
    issue_addr = AW'(ia);
    clear_req  = cr != 0;
    rd_addr    = ra;
    push(nm);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse(input string nm);
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    issue_en  = 1'b0;
    clear_req = 1'b0;
    rd_addr   = NR*AW'($urandom);
    model_reset();
    push(nm);
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic fill();
    for (int i = 1; i < DEPTH; i++) cyc("fill", 1, i, $urandom | 32'h1, 0, 0, 0, NR*AW'($urandom));
  endtask

  task automatic read_all(input string nm);
    for (int r = 0; r < DEPTH / NR; r++) cyc(nm, 0, 0, 0, 0, 0, 0, pk(4*r, 4*r+1, 4*r+2, 4*r+3));
  endtask

  // monitor: compare DUT outputs against the oldest expectation, away from the rising edge
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (rd_data !== e.data || rd_ready !== e.ready || clear_busy !== e.busy) begin
        miscompares++;
        $display("FAIL %s: got data=%h ready=%b busy=%b, want data=%h ready=%b busy=%b",
                 e.name, rd_data, rd_ready, clear_busy, e.data, e.ready, e.busy);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_en = 0; wr_addr = 0; wr_data = 0; issue_en = 0; issue_addr = 0; clear_req = 0;
    rd_addr = pk(1, 2, 3, 4);
    model_reset();
    @(posedge clock);
    #1 push("reset_init");
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    cyc("wr_r5",     1, 5, 32'hDEADBEEF, 0, 0, 0, pk(5, 5, 0, 1));
    cyc("rd_r5",     0, 0, 0,            0, 0, 0, pk(5, 1, 5, 0));
    cyc("byp_r7",    1, 7, 32'h1234,     0, 0, 0, pk(7, 5, 7, 0));
    cyc("wr_r0",     1, 0, 32'hFFFFFFFF, 0, 0, 0, pk(0, 0, 5, 7));
    cyc("rd_r0",     0, 0, 0,            0, 0, 0, pk(0, 5, 7, 0));
    cyc("iss_r3",    0, 0, 0,            1, 3, 0, pk(3, 0, 0, 0));
    cyc("pend_r3",   0, 0, 0,            0, 0, 0, pk(3, 3, 5, 0));
    cyc("wb_r3",     1, 3, 32'h55,       0, 0, 0, pk(3, 3, 0, 0));
    cyc("rdy_r3",    0, 0, 0,            0, 0, 0, pk(3, 0, 3, 0));
    cyc("iss_wb_r3", 1, 3, 32'h55,       1, 3, 0, pk(3, 0, 0, 0));
    cyc("pend2_r3",  0, 0, 0,            0, 0, 0, pk(3, 3, 3, 3));
    cyc("wr_r1",     1, 1, 32'h11,       0, 0, 0, pk(0, 0, 0, 0));
    cyc("wr_r2",     1, 2, 32'h22,       0, 0, 0, pk(1, 2, 0, 0));
    cyc("mp_read",   0, 0, 0,            0, 0, 0, pk(1, 2, 1, 0));
    fill();
    read_all("rd_filled");
    reset_pulse("reset_loaded");
    read_all("rd_after_reset");
    fill();
    cyc("clr_req", 1, 4, 32'h777, 1, 6, 1, pk(4, 6, 0, 1));
    for (int c = 0; c < DEPTH - 1; c++) cyc("clearing", 1, 9, 32'hAAAA, 1, 9, 1, pk(9, 0, c, 31));
    read_all("post_clear");
    fill();
    cyc("clr_req2", 0, 0, 0, 0, 0, 1, pk(1, 2, 3, 4));
    for (int c = 0; c < 10; c++) cyc("clearing2", 0, 0, 0, 0, 0, 0, NR*AW'($urandom));
    reset_pulse("reset_mid_clear");
    read_all("post_mid_reset");
    for (int n = 0; n < 400; n++)
      cyc("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), $urandom,
          int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, 59) == 0), NR*AW'($urandom));
    read_all("final_read");
    wr_en = 0; issue_en = 0; clear_req = 0;
    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
